// File: rtl/ahb_pkg.sv
// Shared AHB constants, bus data width and the register-interface FSM encoding.
package ahb_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_e;

  // NONSEQ and SEQ are the only transfer types that carry a real address phase.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_reg_dec.sv
// Word index to one-hot enable decoder; the vector stays all-zero when enable is low.
module ahb_reg_dec #(
  parameter int NREG = 8,
  parameter int IW   = 6
) (
  input  logic [IW-1:0]   index,
  input  logic            enable,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (enable && (index == IW'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_reg_if.sv
// Zero-wait-state AHB slave front end that turns word transfers into one-hot
// read/write strobes for external registers, with a two-cycle ERROR response.
module ahb_reg_if
  import ahb_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel_i,
  input  logic [AW-1:0]     haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [DATA_W-1:0] hwdata_i,
  input  logic              hready_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DATA_W-1:0] hrdata_o,
  output logic [NREG-1:0]   reg_ren_o,
  output logic [NREG-1:0]   reg_wen_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic [DATA_W-1:0] reg_rdata_i
);

  localparam int IW = AW - 2;

  ahb_state_e state_q, state_d;
  logic [IW-1:0] index_q;
  logic          write_q;
  logic          legal_q;

  logic [IW-1:0] addr_index;
  logic          accept;
  logic          accept_legal;
  logic          data_phase;
  logic          ren_en;
  logic          wen_en;

  assign addr_index = haddr_i[AW-1:2];

  // ERR1 drives HREADY low, so nothing on the bus may be taken during it.
  assign accept = hsel_i && hready_i && is_active(htrans_i) && (state_q != ST_ERR1);

  assign accept_legal = (hsize_i == HSIZE_WORD) &&
                        (haddr_i[1:0] == 2'b00) &&
                        (32'(addr_index) < 32'(NREG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        index_q <= addr_index;
        write_q <= hwrite_i;
        legal_q <= accept_legal;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    data_phase  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = accept_legal ? ST_DATA : ST_ERR1;
      end
      ST_DATA: begin
        data_phase = 1'b1;
        if (accept) state_d = accept_legal ? ST_DATA : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_o = 1'b1;
        if (accept) state_d = accept_legal ? ST_DATA : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ren_en      = data_phase && legal_q && !write_q;
  assign wen_en      = data_phase && legal_q && write_q;
  assign hrdata_o    = ren_en ? reg_rdata_i : '0;
  assign reg_wdata_o = hwdata_i;

  ahb_reg_dec #(.NREG(NREG), .IW(IW)) u_rd_dec (
    .index  (index_q),
    .enable (ren_en),
    .onehot (reg_ren_o)
  );

  ahb_reg_dec #(.NREG(NREG), .IW(IW)) u_wr_dec (
    .index  (index_q),
    .enable (wen_en),
    .onehot (reg_wen_o)
  );

endmodule

// File: tb/tb_ahb_reg_if.sv
// Directed bench for ahb_reg_if: bus-level response-queue model plus downstream register array.
module tb_ahb_reg_if;
  import ahb_pkg::*;

  localparam int NREG = 8;
  localparam int AW   = 8;

  logic        clk;
  logic        rst_n;
  logic        hsel_i;
  logic [7:0]  haddr_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] hwdata_i;
  logic        hready_i;
  logic        hreadyout_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;
  logic [7:0]  reg_ren_o;
  logic [7:0]  reg_wen_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] reg_rdata_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [NREG];
  logic [31:0] model_mem [NREG];
  logic [31:0] pend_wdata;

  typedef struct {
    bit ready;
    bit resp;
    bit data;
    bit write;
    int idx;
  } beat_t;

  beat_t       exp_q [$];
  beat_t       cur;
  logic [7:0]  exp_ren;
  logic [7:0]  exp_wen;
  logic [31:0] exp_rdata;
  logic [7:0]  acc_addr;

  ahb_reg_if #(.NREG(NREG), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsel_i      (hsel_i),
    .haddr_i     (haddr_i),
    .htrans_i    (htrans_i),
    .hwrite_i    (hwrite_i),
    .hsize_i     (hsize_i),
    .hwdata_i    (hwdata_i),
    .hready_i    (hready_i),
    .hreadyout_o (hreadyout_o),
    .hresp_o     (hresp_o),
    .hrdata_o    (hrdata_o),
    .reg_ren_o   (reg_ren_o),
    .reg_wen_o   (reg_wen_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_rdata_i (reg_rdata_i)
  );

  // Single slave on the bus, so the bus-wide HREADY is this slave's own.
  assign hready_i = hreadyout_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream registers: storage lives here, not in the DUT.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reg_wen_o[i]) regs[i] <= reg_wdata_o;
    end
  end

  always_comb begin
    reg_rdata_i = '0;
    for (int i = 0; i < NREG; i++) begin
      if (reg_ren_o[i]) reg_rdata_i = reg_rdata_i | regs[i];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [7:0] addr,
                                input logic [31:0] wdata);
    @(posedge clk);
    #1;
    hsel_i     = sel;
    htrans_i   = trans;
    hwrite_i   = wr;
    hsize_i    = size;
    haddr_i    = addr;
    hwdata_i   = pend_wdata;
    pend_wdata = wdata;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 8'h00, 32'h0);
  endtask

  task automatic wr_word(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] trans);
    apply_stimulus(1'b1, trans, 1'b1, HSIZE_WORD, addr, data);
  endtask

  task automatic rd_word(input logic [7:0] addr);
    apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, 32'h0);
  endtask

  // Every accepted transfer queues its response beats; each cycle consumes one.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check_output("rst_hreadyout", 32'(hreadyout_o), 32'h1);
      check_output("rst_hresp", 32'(hresp_o), 32'h0);
      check_output("rst_ren", 32'(reg_ren_o), 32'h0);
      check_output("rst_wen", 32'(reg_wen_o), 32'h0);
      check_output("rst_hrdata", hrdata_o, 32'h0);
    end else begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{ready: 1'b1, resp: 1'b0, data: 1'b0, write: 1'b0, idx: 0};
      exp_ren   = (cur.data && !cur.write) ? (8'h01 << cur.idx) : 8'h00;
      exp_wen   = (cur.data && cur.write) ? (8'h01 << cur.idx) : 8'h00;
      exp_rdata = (cur.data && !cur.write) ? model_mem[cur.idx] : 32'h0;
      check_output("hreadyout", 32'(hreadyout_o), 32'(cur.ready));
      check_output("hresp", 32'(hresp_o), 32'(cur.resp));
      check_output("reg_ren", 32'(reg_ren_o), 32'(exp_ren));
      check_output("reg_wen", 32'(reg_wen_o), 32'(exp_wen));
      check_output("hrdata", hrdata_o, exp_rdata);
      if (cur.data && cur.write) begin
        check_output("reg_wdata", reg_wdata_o, hwdata_i);
        model_mem[cur.idx] = hwdata_i;
      end
      if (hsel_i && cur.ready && (htrans_i == 2'b10 || htrans_i == 2'b11)) begin
        acc_addr = haddr_i;
        if (hsize_i == 3'b010 && acc_addr[1:0] == 2'b00 && int'(acc_addr) / 4 < NREG) begin
          exp_q.push_back('{ready: 1'b1, resp: 1'b0, data: 1'b1, write: hwrite_i,
                            idx: int'(acc_addr) / 4});
        end else begin
          exp_q.push_back('{ready: 1'b0, resp: 1'b1, data: 1'b0, write: 1'b0, idx: 0});
          exp_q.push_back('{ready: 1'b1, resp: 1'b1, data: 1'b0, write: 1'b0, idx: 0});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREG; i++) begin
      regs[i]      = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
    end
    rst_n      = 1'b0;
    hsel_i     = 1'b0;
    htrans_i   = HTRANS_IDLE;
    hwrite_i   = 1'b0;
    hsize_i    = HSIZE_WORD;
    haddr_i    = '0;
    hwdata_i   = '0;
    pend_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_ready", 32'(hreadyout_o), 32'h1);
    check_output("reset_wen", 32'(reg_wen_o), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle_cycle();

    // Write then read the same word back-to-back.
    wr_word(8'h08, 32'hA5A5_0001, HTRANS_NONSEQ);
    rd_word(8'h08);
    @(negedge clk);
    check_output("raw_wen_pulse", 32'(reg_wen_o), 32'h0000_0004);
    idle_cycle();
    @(negedge clk);
    check_output("raw_rdata", hrdata_o, 32'hA5A5_0001);
    check_output("raw_ready", 32'(hreadyout_o), 32'h1);

    // Out-of-range read gives the two-cycle error.
    rd_word(8'h20);
    idle_cycle();
    @(negedge clk);
    check_output("err1_ready", 32'(hreadyout_o), 32'h0);
    check_output("err1_resp", 32'(hresp_o), 32'h1);
    check_output("err1_ren", 32'(reg_ren_o), 32'h0);
    idle_cycle();
    @(negedge clk);
    check_output("err2_ready", 32'(hreadyout_o), 32'h1);
    check_output("err2_resp", 32'(hresp_o), 32'h1);
    idle_cycle();

    // Halfword write and misaligned word write must both error and leave 0x04 alone.
    apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'b001, 8'h04, 32'hDEAD_0000);
    repeat (3) idle_cycle();
    wr_word(8'h06, 32'hBEEF_0000, HTRANS_NONSEQ);
    repeat (3) idle_cycle();
    check_output("unaligned_reg1", regs[1], 32'h1000_0001);

    // A transfer offered during ERR2 is accepted and served normally.
    rd_word(8'h24);
    rd_word(8'h0C);
    rd_word(8'h0C);
    idle_cycle();
    @(negedge clk);
    check_output("err2_then_read", hrdata_o, 32'h1000_0003);
    idle_cycle();

    // Four pipelined writes followed by four pipelined reads.
    wr_word(8'h00, 32'h1111_0000, HTRANS_NONSEQ);
    wr_word(8'h04, 32'h2222_0001, HTRANS_SEQ);
    @(negedge clk);
    check_output("burst_wen0", 32'(reg_wen_o), 32'h0000_0001);
    wr_word(8'h08, 32'h3333_0002, HTRANS_SEQ);
    @(negedge clk);
    check_output("burst_wen1", 32'(reg_wen_o), 32'h0000_0002);
    wr_word(8'h0C, 32'h4444_0003, HTRANS_SEQ);
    @(negedge clk);
    check_output("burst_wen2", 32'(reg_wen_o), 32'h0000_0004);
    rd_word(8'h00);
    @(negedge clk);
    check_output("burst_wen3", 32'(reg_wen_o), 32'h0000_0008);
    rd_word(8'h04);
    rd_word(8'h08);
    rd_word(8'h0C);
    idle_cycle();
    @(negedge clk);
    check_output("burst_rd3", hrdata_o, 32'h4444_0003);

    // Deselected, BUSY and IDLE cycles have no side effects.
    apply_stimulus(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 8'h10, 32'hCAFE_0000);
    apply_stimulus(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 8'h10, 32'hCAFE_0001);
    apply_stimulus(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 8'h10, 32'hCAFE_0002);
    @(negedge clk);
    check_output("busy_wen", 32'(reg_wen_o), 32'h0);
    check_output("busy_resp", 32'(hresp_o), 32'h0);
    idle_cycle();
    @(negedge clk);
    check_output("busy_no_write", 32'(reg_wen_o), 32'h0);
    rd_word(8'h10);
    idle_cycle();
    @(negedge clk);
    check_output("desel_rd", hrdata_o, 32'h1000_0004);

    // Reset during the data phase of a write aborts it.
    wr_word(8'h14, 32'h5555_AAAA, HTRANS_NONSEQ);
    idle_cycle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("abort_wen", 32'(reg_wen_o), 32'h0);
    check_output("abort_ready", 32'(hreadyout_o), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle_cycle();
    rd_word(8'h14);
    idle_cycle();
    @(negedge clk);
    check_output("abort_rd", hrdata_o, 32'h1000_0005);
    check_output("abort_reg5", regs[5], 32'h1000_0005);
    repeat (2) idle_cycle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
